// File: rtl/jt6295_adpcm_enc.sv
// OKI/MSM6295-compatible 4-bit ADPCM encoder with a successive-approximation quantizer.
// Define JT6295_ENC_PACK_EN to pack two nibbles per output byte (first nibble in [7:4]).
module jt6295_adpcm_enc (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        clr,
  input  logic [11:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [11:0] recon
);

  typedef enum logic [2:0] {IDLE, DIFF, Q2, Q1, Q0, UPD} state_t;

  state_t             state;
  logic        [11:0] smp;
  logic signed [11:0] pred;
  logic        [5:0]  idx;
  logic        [11:0] mag;
  logic        [10:0] step;
  logic               sign, b2, b1, b0;
`ifdef JT6295_ENC_PACK_EN
  logic        [3:0]  half;
  logic               have_half;
`endif

  // Same step table as the decoder, so both sides track the same quantizer scale
  function automatic logic [10:0] step_lut(input logic [5:0] i);
    case (i)
      6'd0:  step_lut = 11'd16;   6'd1:  step_lut = 11'd17;   6'd2:  step_lut = 11'd19;
      6'd3:  step_lut = 11'd21;   6'd4:  step_lut = 11'd23;   6'd5:  step_lut = 11'd25;
      6'd6:  step_lut = 11'd28;   6'd7:  step_lut = 11'd31;   6'd8:  step_lut = 11'd34;
      6'd9:  step_lut = 11'd37;   6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
      6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;   6'd14: step_lut = 11'd60;
      6'd15: step_lut = 11'd66;   6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
      6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;   6'd20: step_lut = 11'd107;
      6'd21: step_lut = 11'd118;  6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
      6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;  6'd26: step_lut = 11'd190;
      6'd27: step_lut = 11'd209;  6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
      6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;  6'd32: step_lut = 11'd337;
      6'd33: step_lut = 11'd371;  6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
      6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;  6'd38: step_lut = 11'd598;
      6'd39: step_lut = 11'd658;  6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
      6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;  6'd44: step_lut = 11'd1060;
      6'd45: step_lut = 11'd1166; 6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
      default: step_lut = 11'd1552;
    endcase
  endfunction

  logic signed [12:0] diff;
  logic        [12:0] diff_abs;
  logic        [11:0] step_h, step_q;
  logic        [12:0] qn;
  logic signed [12:0] pred_sum;
  logic signed [11:0] pred_nxt;
  logic        [5:0]  idx_raw, idx_nxt;
  logic        [3:0]  nibble;
  logic               push_ok;

  assign diff     = $signed({smp[11], smp}) - $signed({pred[11], pred});
  assign diff_abs = diff[12] ? 13'(-diff) : 13'(diff);
  assign step_h   = {2'b0, step[10:1]};
  assign step_q   = {3'b0, step[10:2]};
  assign qn       = {5'b0, step[10:3]}
                  + (b2 ? {2'b0, step}         : 13'd0)
                  + (b1 ? {3'b0, step[10:1]}   : 13'd0)
                  + (b0 ? {4'b0, step[10:2]}   : 13'd0);
  // A sign-0 update can only move pred towards a sample inside -2048..2047, so 13 bits never wrap
  assign pred_sum = sign ? ($signed({pred[11], pred}) - $signed(qn))
                         : ($signed({pred[11], pred}) + $signed(qn));
  assign pred_nxt = (pred_sum > 13'sd2047)  ? 12'sd2047 :
                    (pred_sum < -13'sd2048) ? -12'sd2048 : pred_sum[11:0];
  assign idx_raw  = b2 ? (idx + {3'b0, b1, b0, 1'b0} + 6'd2) : (idx - 6'd1);
  assign idx_nxt  = (idx_raw > 6'd48) ? (b2 ? 6'd48 : 6'd0) : idx_raw;
  assign nibble   = {sign, b2, b1, b0};
  assign push_ok  = !dout_valid || dout_ready;

  assign din_ready = (state == IDLE);
  assign recon     = pred;

  // One FSM steps a sample through difference, three quantizer bits and the predictor update
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      smp        <= 12'd0;
      pred       <= 12'sd0;
      idx        <= 6'd0;
      mag        <= 12'd0;
      step       <= 11'd16;
      sign       <= 1'b0;
      b2         <= 1'b0;
      b1         <= 1'b0;
      b0         <= 1'b0;
      dout       <= 8'd0;
      dout_valid <= 1'b0;
`ifdef JT6295_ENC_PACK_EN
      half       <= 4'd0;
      have_half  <= 1'b0;
`endif
    end else if (cen) begin
      if (clr) begin
        state      <= IDLE;
        pred       <= 12'sd0;
        idx        <= 6'd0;
        dout_valid <= 1'b0;
`ifdef JT6295_ENC_PACK_EN
        have_half  <= 1'b0;
`endif
      end else begin
        if (dout_valid && dout_ready) dout_valid <= 1'b0;
        case (state)
          IDLE: begin
            if (din_valid) begin
              smp   <= din;
              state <= DIFF;
            end
          end
          DIFF: begin
            sign  <= diff[12];
            mag   <= diff_abs[11:0];
            step  <= step_lut(idx);
            state <= Q2;
          end
          Q2: begin
            b2 <= (mag >= {1'b0, step});
            if (mag >= {1'b0, step}) mag <= mag - {1'b0, step};
            state <= Q1;
          end
          Q1: begin
            b1 <= (mag >= step_h);
            if (mag >= step_h) mag <= mag - step_h;
            state <= Q0;
          end
          Q0: begin
            b0    <= (mag >= step_q);
            state <= UPD;
          end
          UPD: begin
            if (push_ok) begin
              pred  <= pred_nxt;
              idx   <= idx_nxt;
              state <= IDLE;
`ifdef JT6295_ENC_PACK_EN
              if (!have_half) begin
                half      <= nibble;
                have_half <= 1'b1;
              end else begin
                dout       <= {half, nibble};
                dout_valid <= 1'b1;
                have_half  <= 1'b0;
              end
`else
              dout       <= {4'b0, nibble};
              dout_valid <= 1'b1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt6295_adpcm_enc.sv
// Randomized bench for jt6295_adpcm_enc against an arithmetic ADPCM reference model.
// Follows JT6295_ENC_PACK_EN in the same way as the design.
module tb_jt6295_adpcm_enc;

  logic        rst = 1'b1;
  logic        clk = 1'b0;
  logic        cen = 1'b1;
  logic        clr = 1'b0;
  logic [11:0] din = 12'd0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [11:0] recon;

  jt6295_adpcm_enc dut (
    .rst        (rst),
    .clk        (clk),
    .cen        (cen),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .recon      (recon)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int expQ[$];
  int mPred, mIdx, mHalf;
  bit mHasHalf;
  int stepTbl[49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66,
                      73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253,
                      279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876,
                      963, 1060, 1166, 1282, 1411, 1552};
  bit sawAccept, readySeen, cenRandom;
  int readyMode;
  int lastDout;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference: textbook OKI quantizer and predictor in plain integer arithmetic
  task automatic modelEncode(input int s);
    int diff, mag, step, code, qn;
    diff = s - mPred;
    mag  = (diff < 0) ? -diff : diff;
    step = stepTbl[mIdx];
    code = 0;
    qn   = step / 8;
    if (mag >= step)     begin code += 4; mag -= step;     qn += step;     end
    if (mag >= step / 2) begin code += 2; mag -= step / 2; qn += step / 2; end
    if (mag >= step / 4) begin code += 1;                  qn += step / 4; end
    mPred = (diff < 0) ? mPred - qn : mPred + qn;
    if (mPred > 2047)  mPred = 2047;
    if (mPred < -2048) mPred = -2048;
    if (code >= 4) mIdx = mIdx + 2 * (code - 4) + 2;
    else           mIdx = mIdx - 1;
    if (mIdx > 48) mIdx = 48;
    if (mIdx < 0)  mIdx = 0;
    if (diff < 0) code += 8;
`ifdef JT6295_ENC_PACK_EN
    if (!mHasHalf) begin
      mHalf    = code;
      mHasHalf = 1'b1;
    end else begin
      expQ.push_back(mHalf * 16 + code);
      mHasHalf = 1'b0;
    end
`else
    expQ.push_back(code);
`endif
  endtask

  task automatic modelClear();
    mPred    = 0;
    mIdx     = 0;
    mHasHalf = 1'b0;
    expQ.delete();
  endtask

  // One clock: sample at the falling edge, then update cen/dout_ready just after the rising edge
  task automatic tick();
    @(negedge clk);
    sawAccept = cen && din_valid && din_ready;
    readySeen = din_ready;
    if (cen && dout_valid && dout_ready) begin
      lastDout = int'(dout);
      if (expQ.size() == 0) checkOutput("unexpected_dout", int'(dout), -1);
      else                  checkOutput("dout", int'(dout), expQ.pop_front());
    end
    @(posedge clk);
    #1;
    cen = cenRandom ? ($urandom_range(0, 3) != 0) : 1'b1;
    case (readyMode)
      0:       dout_ready = 1'b0;
      1:       dout_ready = 1'b1;
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic doReset();
    rst = 1'b1;
    din_valid = 1'b0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelClear();
  endtask

  task automatic applyStimulus(input int s, input bit waitDone, output int cycles);
    int n;
    int r;
    din = 12'(s);
    din_valid = 1'b1;
    cycles = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!sawAccept && n < 400);
    din_valid = 1'b0;
    if (!sawAccept) begin
      checkOutput("accept_timeout", 0, 1);
      return;
    end
    modelEncode(s);
    if (!waitDone) return;
    do begin
      tick();
      cycles++;
    end while (!readySeen && cycles < 400);
    if (!readySeen) checkOutput("done_timeout", 0, 1);
    r = $signed(recon);
    checkOutput("recon", r, mPred);
    checkOutput("idx", int'(dut.idx), mIdx);
  endtask

  initial begin
    int lat, held, r, pre, n;
    bit anyReady, changed, overRange;
    cenRandom = 1'b0;
    readyMode = 1;
    lastDout = -1;
    doReset();

    checkOutput("reset_din_ready", int'(din_ready), 1);
    checkOutput("reset_dout", int'(dout), 0);
    checkOutput("reset_dout_valid", int'(dout_valid), 0);
    checkOutput("reset_recon", int'(recon), 0);
    checkOutput("reset_idx", int'(dut.idx), 0);

    applyStimulus(100, 1'b1, lat);
    checkOutput("latency1", lat, 6);
    checkOutput("recon_100a", int'($signed(recon)), 30);
    checkOutput("idx_100a", int'(dut.idx), 8);
`ifndef JT6295_ENC_PACK_EN
    checkOutput("nibble_100a", lastDout, 7);
`endif
    applyStimulus(100, 1'b1, lat);
    checkOutput("latency2", lat, 6);
    checkOutput("recon_100b", int'($signed(recon)), 93);
    checkOutput("idx_100b", int'(dut.idx), 16);
`ifdef JT6295_ENC_PACK_EN
    checkOutput("packed_byte", lastDout, 'h77);
`else
    checkOutput("nibble_100b", lastDout, 7);
`endif

    doReset();
    applyStimulus(-5, 1'b1, lat);
    checkOutput("recon_neg5", int'($signed(recon)), -6);
    checkOutput("idx_underflow", int'(dut.idx), 0);
`ifndef JT6295_ENC_PACK_EN
    checkOutput("nibble_neg5", lastDout, 9);
`endif

    // Positive full scale, then alternating extremes to drive idx into its upper clamp
    doReset();
    overRange = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(2047, 1'b1, lat);
      r = $signed(recon);
      if (r > 2047) overRange = 1'b1;
    end
    checkOutput("sat_no_overflow", int'(overRange), 0);
    for (int i = 0; i < 20; i++) applyStimulus((i % 2 == 0) ? -2048 : 2047, 1'b1, lat);
    checkOutput("idx_max", int'(dut.idx), mIdx);

    // Output back-pressure: last sample stalls in UPD and the next offer is refused
    repeat (10) tick();
    readyMode = 0;
    dout_ready = 1'b0;
`ifdef JT6295_ENC_PACK_EN
    pre = 3;
`else
    pre = 2;
`endif
    for (int i = 0; i < pre; i++) applyStimulus(300 * (i + 1) - 500, 1'b0, lat);
    repeat (8) tick();
    checkOutput("stall_valid", int'(dout_valid), 1);
    held = int'(dout);
    din = 12'(-1234);
    din_valid = 1'b1;
    anyReady = 1'b0;
    changed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sawAccept || readySeen) anyReady = 1'b1;
      if (int'(dout) != held) changed = 1'b1;
    end
    checkOutput("stall_din_ready", int'(anyReady), 0);
    checkOutput("stall_dout_stable", int'(changed), 0);
    readyMode = 1;
    dout_ready = 1'b1;
    applyStimulus(-1234, 1'b1, lat);
    repeat (10) tick();
    checkOutput("stall_drained", expQ.size(), 0);

    // Synchronous restart in the middle of a sample
    readyMode = 0;
    dout_ready = 1'b0;
    applyStimulus(500, 1'b0, lat);
    tick();
    tick();
    clr = 1'b1;
    cen = 1'b1;
    tick();
    clr = 1'b0;
    modelClear();
    checkOutput("clr_din_ready", int'(din_ready), 1);
    checkOutput("clr_dout_valid", int'(dout_valid), 0);
    checkOutput("clr_recon", int'(recon), 0);
    checkOutput("clr_idx", int'(dut.idx), 0);
    readyMode = 1;
    applyStimulus(100, 1'b1, lat);
    checkOutput("clr_restart_recon", int'($signed(recon)), 30);

    // Random stream with random clock enable and random sink back-pressure
    cenRandom = 1'b1;
    readyMode = 2;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 9);
      if (n == 0)      applyStimulus(2047, 1'b1, lat);
      else if (n == 1) applyStimulus(-2048, 1'b1, lat);
      else             applyStimulus(int'($urandom_range(0, 4095)) - 2048, 1'b1, lat);
    end

    cenRandom = 1'b0;
    readyMode = 1;
    repeat (20) tick();
    checkOutput("drain_empty", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
